// File: rtl/nwc_event_ctrl.sv
// NES-EVENT (mapper 105) core: serial loader, PRG lock FSM, banking, event timer.
// Optional: define NWC_CONSEC_WR_FILTER_EN to drop back-to-back CPU writes.
module nwc_event_ctrl #(
  parameter int TIMER_W = 30,
  parameter int DIP_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_cyc,
  input  logic               cpu_wr,
  input  logic [1:0]         cpu_a14_13,
  input  logic               cpu_a14,
  input  logic [7:0]         cpu_d,
  input  logic [DIP_W-1:0]   dip,
  output logic [3:0]         prg_bank,
  output logic [1:0]         mir,
  output logic               wram_en,
  output logic               irq,
  output logic [TIMER_W-1:0] timer_q
);

  typedef enum logic [1:0] {
    LOCK0,
    LOCK1,
    RUN
  } state_e;

  state_e state_q, state_d;
  logic [4:0] sr_q, sr_d;
  logic [4:0] ctrl_q, ctrl_d;
  logic [4:0] r1_q, r1_d;
  logic [4:0] r3_q, r3_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic [TIMER_W-1:0] target;
  logic irq_q, irq_d;
  logic wr_ok;
  logic commit;
  logic [4:0] val;
  logic [2:0] b;

`ifdef NWC_CONSEC_WR_FILTER_EN
  logic acc_q, acc_d;

  assign wr_ok = cpu_wr & acc_q;

  // A write closes the window; any M2 cycle reopens it.
  always_comb begin
    acc_d = acc_q;
    if (wr_ok) acc_d = 1'b0;
    if (cpu_cyc) acc_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= 1'b1;
    else        acc_q <= acc_d;
  end
`else
  assign wr_ok = cpu_wr;
`endif

  assign val = {cpu_d[0], sr_q[4:1]};

  always_comb begin
    sr_d    = sr_q;
    ctrl_d  = ctrl_q;
    r1_d    = r1_q;
    r3_d    = r3_q;
    state_d = state_q;
    commit  = 1'b0;
    if (wr_ok) begin
      if (cpu_d[7]) begin
        sr_d        = 5'b10000;
        ctrl_d[3:2] = 2'b11;
      end else if (sr_q[0]) begin
        sr_d   = 5'b10000;
        commit = 1'b1;
      end else begin
        sr_d = val;
      end
    end
    if (commit) begin
      unique case (cpu_a14_13)
        2'd0:    ctrl_d = val;
        2'd1:    r1_d   = val;
        2'd3:    r3_d   = val;
        default: ;
      endcase
    end
    if (commit && cpu_a14_13 == 2'd1) begin
      unique case (state_q)
        LOCK0:   if (!val[4]) state_d = LOCK1;
        LOCK1:   if (val[4])  state_d = RUN;
        default: ;
      endcase
    end
  end

  always_comb begin
    target = '0;
    target[TIMER_W-1] = 1'b1;
    target[TIMER_W-2 -: DIP_W] = dip;
  end

  // r1_d gives a same-clk commit of I priority over the increment.
  always_comb begin
    cnt_d = cnt_q;
    irq_d = irq_q;
    if (state_q != RUN || r1_d[4]) begin
      cnt_d = '0;
      irq_d = 1'b0;
    end else begin
      if (cnt_q == target) irq_d = 1'b1;
      if (cpu_cyc && cnt_q != target) cnt_d = cnt_q + TIMER_W'(1);
    end
  end

  always_comb begin
    b = {r3_q[2:1], cpu_a14};
    unique case (1'b1)
      (ctrl_q[3:2] == 2'd2): b = cpu_a14 ? r3_q[2:0] : 3'd0;
      (ctrl_q[3:2] == 2'd3): b = cpu_a14 ? 3'd7 : r3_q[2:0];
      default:               b = {r3_q[2:1], cpu_a14};
    endcase
    if (state_q != RUN)  prg_bank = {3'b000, cpu_a14};
    else if (!r1_q[3])   prg_bank = {1'b0, r1_q[2:1], cpu_a14};
    else                 prg_bank = {1'b1, b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= 5'b10000;
      ctrl_q  <= 5'b01100;
      r1_q    <= 5'b10000;
      r3_q    <= 5'b00000;
      state_q <= LOCK0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      ctrl_q  <= ctrl_d;
      r1_q    <= r1_d;
      r3_q    <= r3_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end

  assign mir     = ctrl_q[1:0];
  assign wram_en = ~r3_q[4];
  assign irq     = irq_q;
  assign timer_q = cnt_q;

  logic unused_w;
  assign unused_w = ^{cpu_d[6:1], ctrl_q[4], r1_q[0], r3_q[3]};

endmodule
